// File: rtl/address_sequencer.sv
// Address sequencer for the storage write path.
// Issues one address per ready cycle, either as a linear sweep 0..NADDR-1
// or by replaying a runtime-loaded {x,y} coordinate list. Supports one-shot
// or continuous looping, restart on start, and downstream backpressure.
module address_sequencer #(
  parameter int ADDRESSBITS = 8,
  parameter int NADDR       = 2**ADDRESSBITS,
  parameter int LISTDEPTH   = 32,
  parameter int LISTIDXBITS = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   loopEn,
  input  logic [LISTIDXBITS:0]   listLength,
  input  logic                   storageReady,
  input  logic                   listWrEn,
  input  logic [LISTIDXBITS-1:0] listWrIndex,
  input  logic [ADDRESSBITS-1:0] listWrData,
  output logic [ADDRESSBITS-1:0] address,
  output logic                   newAddress,
  output logic                   busy,
  output logic                   done
);

  // The index must span both the linear range and the list range.
  localparam int CNTW = (ADDRESSBITS > LISTIDXBITS + 1) ? ADDRESSBITS : LISTIDXBITS + 1;
  localparam logic [LISTIDXBITS:0] DEPTHLEN = LISTDEPTH[LISTIDXBITS:0];
  localparam logic [LISTIDXBITS:0] ONELEN   = 1;
  localparam logic [CNTW-1:0]      ONECNT   = 1;
  localparam logic [CNTW-1:0]      LASTLIN  = CNTW'(NADDR - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT                  state;
  stateT                  nextState;
  logic [CNTW-1:0]        index;
  logic [CNTW-1:0]        lastIdx;
  logic                   modeR;
  logic                   loopR;
  logic [LISTIDXBITS:0]   lenClamped;
  logic [ADDRESSBITS-1:0] issueValue;
  logic [ADDRESSBITS-1:0] listMem [LISTDEPTH];

  // Clamp the requested list length and pick the address source for this cycle.
  always_comb begin
    lenClamped = (listLength > DEPTHLEN) ? DEPTHLEN : listLength;
    issueValue = modeR ? listMem[index[LISTIDXBITS-1:0]] : index[ADDRESSBITS-1:0];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next state: start always (re)launches a pass; an empty list goes straight to DONE.
  always_comb begin
    nextState = state;
    if (start) begin
      nextState = (mode && (lenClamped == '0)) ? DONE : RUN;
    end else if (state == RUN && storageReady && index == lastIdx && !loopR) begin
      nextState = DONE;
    end
  end

  // Status outputs; done waits until the final strobe has been presented.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE) && !newAddress;
  end

  // Issue datapath: latch config on start, otherwise issue while downstream is ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      address    <= '0;
      newAddress <= 1'b0;
      index      <= '0;
      modeR      <= 1'b0;
      loopR      <= 1'b0;
      lastIdx    <= '0;
    end else begin
      newAddress <= 1'b0;
      if (start) begin
        modeR   <= mode;
        loopR   <= loopEn;
        lastIdx <= mode ? CNTW'(lenClamped - ONELEN) : LASTLIN;
        index   <= '0;
      end else if (state == RUN && storageReady) begin
        address    <= issueValue;
        newAddress <= 1'b1;
        if (index == lastIdx) index <= '0;
        else                  index <= index + ONECNT;
      end
    end
  end

  // Coordinate list storage; frozen while a pass is running, not cleared by reset.
  always_ff @(posedge clock) begin
    if (listWrEn && state != RUN) listMem[listWrIndex] <= listWrData;
  end

endmodule

// File: tb/tb_address_sequencer.sv
// Directed testbench for address_sequencer (ADDRESSBITS=8, NADDR=16, LISTDEPTH=32).
module tb_address_sequencer;

  logic       clock;
  logic       reset;
  logic       start;
  logic       mode;
  logic       loopEn;
  logic [5:0] listLength;
  logic       storageReady;
  logic       listWrEn;
  logic [4:0] listWrIndex;
  logic [7:0] listWrData;
  logic [7:0] address;
  logic       newAddress;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int pat [10] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1};

  address_sequencer #(
    .ADDRESSBITS(8),
    .NADDR(16),
    .LISTDEPTH(32),
    .LISTIDXBITS(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .mode(mode),
    .loopEn(loopEn),
    .listLength(listLength),
    .storageReady(storageReady),
    .listWrEn(listWrEn),
    .listWrIndex(listWrIndex),
    .listWrData(listWrData),
    .address(address),
    .newAddress(newAddress),
    .busy(busy),
    .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Contents used for the 21-entry replay list.
  function automatic logic [7:0] entryOf(int i);
    case (i)
      0:       return 8'h04;
      1:       return 8'hD0;
      2:       return 8'h1F;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (address !== 8'h00) begin errors++; $display("FAIL reset_address got %h want 00", address); end
    checks++; if (newAddress !== 1'b0) begin errors++; $display("FAIL reset_newAddress got %b want 0", newAddress); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_linear_oneshot();
    int strobes;
    mode = 1'b0; loopEn = 1'b0; storageReady = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (newAddress !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL lin_start_cycle got nA=%b busy=%b want nA=0 busy=1", newAddress, busy); end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (newAddress !== 1'b1 || address !== 8'(i)) begin
        errors++; $display("FAIL lin_issue[%0d] got nA=%b addr=%h want nA=1 addr=%h", i, newAddress, address, 8'(i));
      end
    end
    tick();
    checks++; if (done !== 1'b1 || newAddress !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lin_done got done=%b nA=%b busy=%b want 1 0 0", done, newAddress, busy); end
    strobes = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (newAddress === 1'b1) strobes++; end
    checks++; if (strobes != 0) begin errors++; $display("FAIL lin_after_done strobes got %0d want 0", strobes); end
  endtask

  task automatic test_list_replay();
    int strobes;
    storageReady = 1'b1;
    for (int i = 0; i < 21; i++) begin
      listWrEn = 1'b1; listWrIndex = 5'(i); listWrData = entryOf(i);
      tick();
    end
    listWrEn = 1'b0;
    mode = 1'b1; loopEn = 1'b0; listLength = 6'd21; start = 1'b1;
    tick();
    start = 1'b0;
    strobes = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      if (newAddress === 1'b1) strobes++;
      checks++;
      if (newAddress !== 1'b1 || address !== entryOf(i)) begin
        errors++; $display("FAIL list_issue[%0d] got nA=%b addr=%h want nA=1 addr=%h", i, newAddress, address, entryOf(i));
      end
    end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL list_done got %b want 1", done); end
    for (int i = 0; i < 3; i++) begin tick(); if (newAddress === 1'b1) strobes++; end
    checks++; if (strobes != 21) begin errors++; $display("FAIL list_strobe_count got %0d want 21", strobes); end
  endtask

  task automatic test_backpressure();
    int idx;
    int strobes;
    logic expNa;
    logic [7:0] lastAddr;
    mode = 1'b1; loopEn = 1'b0; listLength = 6'd4; storageReady = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0; strobes = 0; lastAddr = entryOf(20);
    for (int c = 0; c < 10; c++) begin
      storageReady = pat[c][0];
      tick();
      if (pat[c] == 1 && idx < 4) begin expNa = 1'b1; lastAddr = entryOf(idx); idx++; end
      else expNa = 1'b0;
      if (newAddress === 1'b1) strobes++;
      checks++;
      if (newAddress !== expNa || address !== lastAddr) begin
        errors++; $display("FAIL bp_cycle[%0d] got nA=%b addr=%h want nA=%b addr=%h", c, newAddress, address, expNa, lastAddr);
      end
    end
    storageReady = 1'b1;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b want 1", done); end
    checks++; if (strobes != 4) begin errors++; $display("FAIL bp_strobe_count got %0d want 4", strobes); end
  endtask

  task automatic test_loop();
    logic [7:0] seq [3];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      listWrEn = 1'b1; listWrIndex = 5'(i); listWrData = seq[i];
      tick();
    end
    listWrEn = 1'b0;
    mode = 1'b1; loopEn = 1'b1; listLength = 6'd3; storageReady = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (newAddress !== 1'b1 || address !== seq[i % 3] || done !== 1'b0) begin
        errors++; $display("FAIL loop_issue[%0d] got nA=%b addr=%h done=%b want nA=1 addr=%h done=0", i, newAddress, address, done, seq[i % 3]);
      end
    end
  endtask

  task automatic test_restart_and_write();
    logic [7:0] exp1 [3];
    logic [7:0] exp2 [3];
    exp1[0] = 8'h11; exp1[1] = 8'h22; exp1[2] = 8'h33;
    exp2[0] = 8'h11; exp2[1] = 8'h99; exp2[2] = 8'h33;
    // Still looping: restart with one-shot config and try to overwrite entry 1.
    mode = 1'b1; loopEn = 1'b0; listLength = 6'd3; storageReady = 1'b1; start = 1'b1;
    listWrEn = 1'b1; listWrIndex = 5'd1; listWrData = 8'h99;
    tick();
    start = 1'b0; listWrEn = 1'b0;
    checks++; if (newAddress !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_suppress got nA=%b busy=%b want 0 1", newAddress, busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (newAddress !== 1'b1 || address !== exp1[i]) begin
        errors++; $display("FAIL restart_issue[%0d] got nA=%b addr=%h want nA=1 addr=%h", i, newAddress, address, exp1[i]);
      end
    end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", done); end
    // In DONE: write and start together, the pass must see the new entry.
    listWrEn = 1'b1; listWrIndex = 5'd1; listWrData = 8'h99; start = 1'b1;
    tick();
    listWrEn = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (newAddress !== 1'b1 || address !== exp2[i]) begin
        errors++; $display("FAIL done_write_issue[%0d] got nA=%b addr=%h want nA=1 addr=%h", i, newAddress, address, exp2[i]);
      end
    end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_write_done got %b want 1", done); end
  endtask

  task automatic test_zero_length();
    int strobes;
    mode = 1'b1; loopEn = 1'b0; listLength = 6'd0; storageReady = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || newAddress !== 1'b0) begin errors++; $display("FAIL zero_len got done=%b busy=%b nA=%b want 1 0 0", done, busy, newAddress); end
    strobes = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (newAddress === 1'b1) strobes++; end
    checks++; if (strobes != 0) begin errors++; $display("FAIL zero_len_strobes got %0d want 0", strobes); end
  endtask

  task automatic test_oversize_length();
    int strobes;
    mode = 1'b1; loopEn = 1'b0; listLength = 6'd40; storageReady = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    strobes = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (newAddress === 1'b1) strobes++; end
    checks++; if (strobes != 32) begin errors++; $display("FAIL oversize_strobes got %0d want 32", strobes); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL oversize_done got %b want 1", done); end
  endtask

  task automatic test_reset_mid_pass();
    mode = 1'b0; loopEn = 1'b0; storageReady = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    checks++; if (address !== 8'h00 || newAddress !== 1'b0) begin errors++; $display("FAIL midreset_addr got addr=%h nA=%b want 00 0", address, newAddress); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_status got busy=%b done=%b want 0 0", busy, done); end
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (newAddress !== 1'b0) begin errors++; $display("FAIL midreset_first got nA=%b want 0", newAddress); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (newAddress !== 1'b1 || address !== 8'(i)) begin
        errors++; $display("FAIL midreset_issue[%0d] got nA=%b addr=%h want nA=1 addr=%h", i, newAddress, address, 8'(i));
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; loopEn = 1'b0; listLength = '0;
    storageReady = 1'b0; listWrEn = 1'b0; listWrIndex = '0; listWrData = '0;
    test_reset();
    test_linear_oneshot();
    test_list_replay();
    test_backpressure();
    test_loop();
    test_restart_and_write();
    test_zero_length();
    test_oversize_length();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/address_sequencer.md
Name: address_sequencer

Overview:
- Parametrised address generator feeding the storage/memory write path; drives one address per accepted cycle with a single-cycle newAddress strobe.
- Two modes: linear sweep over a configurable range, or replay of a runtime-loadable coordinate list packed as {x,y}.
- Adds start/done control, one-shot vs continuous looping, and a synchronous reset.
- Issues every list entry exactly once per pass, with no dropped tail entries and no padding entries.

Parameters:
- ADDRESSBITS, 8, output address width; must be even; x = upper half, y = lower half.
- NADDR, 2**ADDRESSBITS, number of addresses in linear-sweep mode (1..2**ADDRESSBITS).
- LISTDEPTH, 32, entries in the internal coordinate list.
- LISTIDXBITS, 5, index width, ceil(log2(LISTDEPTH)).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches mode/loopEn/listLength and begins a pass.
- mode  input  1  0 = linear sweep, 1 = list replay.
- loopEn  input  1  1 = wrap and continue forever; 0 = one pass then DONE.
- listLength  input  LISTIDXBITS+1  number of valid list entries, 0..LISTDEPTH.
- storageReady  input  1  downstream can accept an address this cycle.
- listWrEn  input  1  list write strobe.
- listWrIndex  input  LISTIDXBITS  list write index.
- listWrData  input  ADDRESSBITS  {x,y} entry.
- address  output  ADDRESSBITS  current address (registered).
- newAddress  output  1  high for one cycle when address holds a new value.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; address = 0, newAddress = 0, busy = 0, done = 0, index = 0. List contents are not cleared.
- States:
  - IDLE: start -> RUN, index = 0.
  - RUN: one issue per cycle while storageReady = 1.
  - DONE: done = 1 is held; start -> RUN (restart); otherwise stay.
- Issue:
  - In RUN with storageReady = 1 at edge k, address and newAddress = 1 are valid after edge k (latency 1).
  - Address source: linear mode uses the index; list mode uses list[index].
  - Index increments after each issue.
  - storageReady = 0 in RUN: newAddress = 0 next cycle, address holds, index holds.
- Last element (index = N-1, where N = NADDR for linear or latched listLength for list):
  - loopEn = 1: the next index is 0; RUN continues with no bubble.
  - loopEn = 0: the last address issues normally, then state -> DONE on the same edge. done is asserted the cycle after the final newAddress.
- N = 0 (list mode, listLength = 0): start -> DONE directly, with no newAddress.
- listLength > LISTDEPTH: treated as LISTDEPTH.
- newAddress is never high for two consecutive cycles unless storageReady stayed high; each high cycle corresponds to exactly one issued element.
- start while in RUN: restart on the next edge. Index = 0, new config is latched, and the issue on that cycle is suppressed (newAddress = 0).
- start in IDLE with storageReady = 1: the first address issues on the following edge, not the same edge.
- List writes:
  - Accepted in IDLE/DONE and ignored in RUN.
  - A write to the index being replayed does not affect the current pass.
  - A write and start in the same cycle: the write lands first, so the pass sees the new entry.
- Reset mid-RUN: returns to IDLE on that edge; newAddress = 0 that cycle.
- Config inputs are sampled only at start; changes during RUN have no effect.
- Linear wrap: the counter never exceeds NADDR-1. With NADDR = 2**ADDRESSBITS, wrap is the natural overflow 255 -> 0.

Test Plan:
- Linear one-shot, NADDR=16, loopEn=0, storageReady=1: newAddress for 16 consecutive cycles with address 0..15; done=1 the cycle after address 15; no further strobes.
- List replay with 21 entries (e.g. {0,4},{13,0},{1,15},...), listLength=21, loopEn=0: all 21 issued in order, the last entry included; exactly 21 strobes; done asserted.
- Backpressure: list mode with storageReady toggling 1,0,0,1: address holds during the 0 cycles; no skipped or duplicated entries; strobe count equals the number of ready cycles.
- Loop mode, listLength=3 with entries 0x11,0x22,0x33, storageReady=1 for 9 cycles: sequence 11,22,33,11,22,33,11,22,33; done stays 0.
- Edge cases: listLength=0 -> done with zero strobes; start mid-RUN -> one suppressed cycle, then the first element; list write during RUN is ignored, and the same write in DONE is replayed on the next pass.
- Reset asserted mid-pass -> next cycle IDLE with address=0, newAddress=0, busy=0; a new start replays from index 0.
